// File: rtl/icpit_svc_pkg.sv
// Shared types, default register map and priority encoder for the ICPIT IRQ servicer.
package icpit_svc_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdSetup,
      StRdAccess,
      StDeliver,
      StClrSetup,
      StClrAccess,
      StKickSetup,
      StKickAccess
   } svc_state_e;

   localparam logic [7:0]  DefStatusAddr = 8'h00;
   localparam logic [7:0]  DefClearAddr  = 8'h04;
   localparam logic [7:0]  DefWdogAddr   = 8'h10;
   localparam logic [31:0] DefWdogKey    = 32'h0000_A5A5;

   // Index of the lowest set bit; bit 0 is the highest-priority source.
   function automatic logic [2:0] prio_enc(input logic [7:0] req);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (req[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/icpit_kick_timer.sv
// Free-running watchdog kick timer: raises a sticky pending flag every Period cycles.
module icpit_kick_timer #(
   parameter int unsigned Period = 1000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   output logic pending_o
);

   localparam int unsigned    CntW   = $clog2(Period);
   localparam logic [CntW-1:0] Reload = CntW'(Period - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            pending_q, pending_d;
   logic            expire;

   // Count down, reload at zero; an expiry while already pending is absorbed.
   always_comb begin
      expire    = (cnt_q == '0);
      cnt_d     = expire ? Reload : cnt_q - CntW'(1);
      pending_d = expire | (pending_q & ~clr_i);
   end

   // Counter and pending flag state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= Reload;
         pending_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
      end
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/icpit_irq_servicer.sv
// APB master that services ICPIT interrupts for a local consumer and kicks the watchdog.
module icpit_irq_servicer
   import icpit_svc_pkg::*;
#(
   parameter int unsigned        ADDR_W      = 8,
   parameter logic [ADDR_W-1:0]  STATUS_ADDR = ADDR_W'(DefStatusAddr),
   parameter logic [ADDR_W-1:0]  CLEAR_ADDR  = ADDR_W'(DefClearAddr),
   parameter logic [ADDR_W-1:0]  WDOG_ADDR   = ADDR_W'(DefWdogAddr),
   parameter logic [31:0]        WDOG_KEY    = DefWdogKey,
   parameter int unsigned        KICK_PERIOD = 1000
) (
   input  logic              PCLK,
   input  logic              PRESETN,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [31:0]       PWDATA,
   input  logic [31:0]       PRDATA,
   input  logic              PREADY,
   input  logic              IRQ,
   input  logic              WDOG,
   output logic              irq_valid,
   output logic [2:0]        irq_id,
   input  logic              irq_ack,
   output logic [7:0]        spurious_cnt,
   output logic              wdog_fired
);

   svc_state_e state_q, state_d;
   logic [2:0] irq_id_q, irq_id_d;
   logic [7:0] spurious_q, spurious_d;
   logic       wdog_fired_q;
   logic       kick_pending, kick_clr;
   logic [7:0] status;
   logic       rd_done;
   logic       unused_prdata;

   assign status        = PRDATA[7:0];
   assign unused_prdata = ^PRDATA[31:8];
   assign rd_done       = (state_q == StRdAccess) && PREADY;
   assign kick_clr      = (state_q == StKickAccess) && PREADY;

   icpit_kick_timer #(
      .Period (KICK_PERIOD)
   ) u_kick_timer (
      .clk_i     (PCLK),
      .rst_ni    (PRESETN),
      .clr_i     (kick_clr),
      .pending_o (kick_pending)
   );

   // State register; outputs decode from it, so reset drops PSEL/PENABLE at once.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; kicks win arbitration in IDLE and are never started mid-transfer.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (kick_pending)  state_d = StKickSetup;
            else if (IRQ)      state_d = StRdSetup;
         end
         StRdSetup:    state_d = StRdAccess;
         StRdAccess:   if (PREADY) state_d = (status != '0) ? StDeliver : StIdle;
         StDeliver:    if (irq_ack) state_d = StClrSetup;
         StClrSetup:   state_d = StClrAccess;
         StClrAccess:  if (PREADY) state_d = StIdle;
         StKickSetup:  state_d = StKickAccess;
         StKickAccess: if (PREADY) state_d = StIdle;
         default:      state_d = StIdle;
      endcase
   end

   // Source index and spurious counter update on read completion.
   always_comb begin
      irq_id_d   = irq_id_q;
      spurious_d = spurious_q;
      if (rd_done) begin
         if (status != '0) begin
            irq_id_d = prio_enc(status);
         end else if (spurious_q != 8'hFF) begin
            spurious_d = spurious_q + 8'd1;
         end
      end
   end

   // Datapath registers and sticky watchdog flag.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         irq_id_q     <= 3'd0;
         spurious_q   <= 8'd0;
         wdog_fired_q <= 1'b0;
      end else begin
         irq_id_q     <= irq_id_d;
         spurious_q   <= spurious_d;
         wdog_fired_q <= wdog_fired_q | WDOG;
      end
   end

   // APB and consumer outputs; address and data are pure functions of state, hence stable.
   always_comb begin
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      PWRITE    = 1'b0;
      PADDR     = '0;
      PWDATA    = '0;
      irq_valid = 1'b0;
      unique case (state_q)
         StRdSetup, StRdAccess: begin
            PSEL    = 1'b1;
            PENABLE = (state_q == StRdAccess);
            PADDR   = STATUS_ADDR;
         end
         StDeliver: irq_valid = 1'b1;
         StClrSetup, StClrAccess: begin
            PSEL    = 1'b1;
            PENABLE = (state_q == StClrAccess);
            PWRITE  = 1'b1;
            PADDR   = CLEAR_ADDR;
            PWDATA  = 32'd1 << irq_id_q;
         end
         StKickSetup, StKickAccess: begin
            PSEL    = 1'b1;
            PENABLE = (state_q == StKickAccess);
            PWRITE  = 1'b1;
            PADDR   = WDOG_ADDR;
            PWDATA  = WDOG_KEY;
         end
         default: ;
      endcase
   end

   assign irq_id       = irq_id_q;
   assign spurious_cnt = spurious_q;
   assign wdog_fired   = wdog_fired_q;

endmodule

// File: tb/tb_icpit_irq_servicer.sv
// Scoreboard bench for icpit_irq_servicer: APB slave model, event monitor, directed stimulus.
`timescale 1ns/1ps
module tb_icpit_irq_servicer;

   localparam int unsigned K     = 600;
   localparam logic [7:0]  ST_A  = 8'h00;
   localparam logic [7:0]  CLR_A = 8'h04;
   localparam logic [7:0]  WD_A  = 8'h10;
   localparam logic [31:0] KEY   = 32'h0000_A5A5;
   localparam logic [1:0]  KRD   = 2'd0;
   localparam logic [1:0]  KWR   = 2'd1;
   localparam logic [1:0]  KDLV  = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [7:0]  addr;
      logic [31:0] data;
   } ev_t;

   logic        PCLK = 1'b0;
   logic        PRESETN = 1'b0;
   logic [7:0]  PADDR;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA = '0;
   logic        PREADY;
   logic        IRQ = 1'b0;
   logic        WDOG = 1'b0;
   logic        irq_valid;
   logic [2:0]  irq_id;
   logic        irq_ack = 1'b0;
   logic [7:0]  spurious_cnt;
   logic        wdog_fired;

   logic        ready_r = 1'b0;
   int          checks = 0;
   int          failures = 0;
   int          ncyc = 0;
   int          wait_cfg = 0;
   int          wait_left = 0;
   int          kick_cnt = 0;
   int          last_kick_cyc = 0;
   bit          kicks_scored = 1'b0;
   ev_t         exp_q[$];
   logic [7:0]  status_q[$];

   assign PREADY = ready_r & PSEL & PENABLE;

   icpit_irq_servicer #(
      .ADDR_W      (8),
      .STATUS_ADDR (ST_A),
      .CLEAR_ADDR  (CLR_A),
      .WDOG_ADDR   (WD_A),
      .WDOG_KEY    (KEY),
      .KICK_PERIOD (K)
   ) dut (
      .PCLK         (PCLK),
      .PRESETN      (PRESETN),
      .PADDR        (PADDR),
      .PSEL         (PSEL),
      .PENABLE      (PENABLE),
      .PWRITE       (PWRITE),
      .PWDATA       (PWDATA),
      .PRDATA       (PRDATA),
      .PREADY       (PREADY),
      .IRQ          (IRQ),
      .WDOG         (WDOG),
      .irq_valid    (irq_valid),
      .irq_id       (irq_id),
      .irq_ack      (irq_ack),
      .spurious_cnt (spurious_cnt),
      .wdog_fired   (wdog_fired)
   );

   initial forever #5 PCLK = ~PCLK;

   always @(posedge PCLK) ncyc <= ncyc + 1;

   initial begin
      #1ms;
      $display("FAIL global_timeout: got no end of test, required finish");
      $fatal(1, "timeout");
   end

   function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, ncyc);
      end
   endfunction

   function automatic ev_t mk(input logic [1:0] k, input logic [7:0] a, input logic [31:0] d);
      ev_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      return e;
   endfunction

   function automatic void sb(input string name, input ev_t got);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_%s: got kind=%0d addr=%0h data=%0h required no event (cycle %0d)",
                  name, got.kind, got.addr, got.data, ncyc);
      end else begin
         e = exp_q.pop_front();
         chk({"sb_", name}, 64'(got), 64'(e));
      end
   endfunction

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: got timeout required event within budget (cycle %0d)", name, ncyc);
   endtask

   // APB slave model plus monitor; everything observed on the falling edge.
   initial begin : monitor
      logic [7:0]  s_addr;
      logic        s_write;
      logic [31:0] s_wdata;
      logic        prev_valid;
      logic [2:0]  id_hold;
      s_addr = '0; s_write = 1'b0; s_wdata = '0; prev_valid = 1'b0; id_hold = '0;
      forever begin
         @(negedge PCLK);
         if (!PRESETN) begin
            ready_r    = 1'b0;
            prev_valid = 1'b0;
         end else begin
            if (irq_valid && !prev_valid) begin
               sb("deliver", mk(KDLV, 8'h00, {29'd0, irq_id}));
               id_hold = irq_id;
            end else if (irq_valid) begin
               chk("irq_id_stable", 64'(irq_id), 64'(id_hold));
            end
            prev_valid = irq_valid;
            if (PSEL && !PENABLE) begin
               s_addr = PADDR; s_write = PWRITE; s_wdata = PWDATA;
               wait_left = wait_cfg;
               ready_r = 1'b0;
            end else if (PSEL && PENABLE) begin
               chk("apb_stable", 64'({PADDR, PWRITE, PWDATA}), 64'({s_addr, s_write, s_wdata}));
               if (wait_left > 0) begin
                  wait_left--;
                  ready_r = 1'b0;
               end else begin
                  ready_r = 1'b1;
                  if (!PWRITE) begin
                     if (status_q.size() > 0) PRDATA = {24'd0, status_q.pop_front()};
                     else PRDATA = 32'd0;
                     sb("read", mk(KRD, PADDR, PRDATA));
                  end else if (PADDR == WD_A) begin
                     kick_cnt++;
                     last_kick_cyc = ncyc;
                     if (kicks_scored) sb("kick", mk(KWR, PADDR, PWDATA));
                     else chk("kick_data", 64'(PWDATA), 64'(KEY));
                  end else begin
                     sb("write", mk(KWR, PADDR, PWDATA));
                  end
               end
            end else begin
               ready_r = 1'b0;
            end
         end
      end
   end

   task automatic wait_valid(input string name, input bit drop, output int lat);
      lat = 0;
      do begin
         @(negedge PCLK);
         lat++;
         if (drop && PSEL && !PENABLE && !PWRITE) IRQ = 1'b0;
      end while (!irq_valid && lat < 200);
      if (!irq_valid) timeout({name, "_valid"});
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || PSEL) && n < 300) begin
         @(negedge PCLK);
         n++;
      end
      if (exp_q.size() != 0) begin
         timeout({name, "_drain"});
         exp_q.delete();
      end
   endtask

   task automatic wait_until(input int t);
      if (ncyc > t) timeout("schedule");
      while (ncyc < t) @(negedge PCLK);
   endtask

   task automatic wait_kicks(input int n);
      int start, t;
      start = kick_cnt;
      t = 0;
      while (kick_cnt < start + n && t < 3 * K) begin
         @(negedge PCLK);
         t++;
      end
      if (kick_cnt < start + n) timeout("kick_sync");
   endtask

   // One interrupt round trip with a hand-computed id, clear word and latency (-1 skips it).
   task automatic service(input logic [7:0] st, input logic [2:0] id, input logic [31:0] clr,
                          input int exp_lat, input string name);
      int lat, n;
      status_q.push_back(st);
      exp_q.push_back(mk(KRD, ST_A, {24'd0, st}));
      if (st != 8'h00) begin
         exp_q.push_back(mk(KDLV, 8'h00, {29'd0, id}));
         exp_q.push_back(mk(KWR, CLR_A, clr));
      end
      @(negedge PCLK);
      IRQ = 1'b1;
      if (st != 8'h00) begin
         wait_valid(name, 1'b1, lat);
         if (exp_lat >= 0) chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
         irq_ack = 1'b1;
         @(negedge PCLK);
         irq_ack = 1'b0;
         chk({name, "_clr_setup"}, 64'({PSEL, PENABLE, PWRITE, PADDR}), 64'({3'b101, CLR_A}));
      end else begin
         n = 0;
         while (IRQ && n < 200) begin
            @(negedge PCLK);
            n++;
            if (PSEL && !PENABLE && !PWRITE) IRQ = 1'b0;
         end
         IRQ = 1'b0;
      end
      drain(name);
   endtask

   initial begin : stim
      int lat, c_o;
      repeat (3) @(negedge PCLK);
      PRESETN = 1'b1;
      @(negedge PCLK);
      chk("rst_apb_ctl", 64'({PSEL, PENABLE, PWRITE}), 64'(0));
      chk("rst_paddr", 64'(PADDR), 64'(0));
      chk("rst_pwdata", 64'(PWDATA), 64'(0));
      chk("rst_irq", 64'({irq_valid, irq_id}), 64'(0));
      chk("rst_spurious", 64'(spurious_cnt), 64'(0));
      chk("rst_wdog_fired", 64'(wdog_fired), 64'(0));

      service(8'h20, 3'd5, 32'h20, 3, "single");
      wait_cfg = 3;
      service(8'h01, 3'd0, 32'h01, 6, "wait_states");
      wait_cfg = 0;

      // Acknowledge with nothing presented must do nothing.
      irq_ack = 1'b1;
      repeat (3) @(negedge PCLK);
      irq_ack = 1'b0;
      chk("ack_idle", 64'({irq_valid, PSEL}), 64'(0));

      // Priority with IRQ held across the first clear.
      status_q.push_back(8'hA4);
      status_q.push_back(8'hA0);
      exp_q.push_back(mk(KRD, ST_A, 32'hA4));
      exp_q.push_back(mk(KDLV, 8'h00, 32'd2));
      exp_q.push_back(mk(KWR, CLR_A, 32'h04));
      exp_q.push_back(mk(KRD, ST_A, 32'hA0));
      exp_q.push_back(mk(KDLV, 8'h00, 32'd5));
      exp_q.push_back(mk(KWR, CLR_A, 32'h20));
      @(negedge PCLK);
      IRQ = 1'b1;
      wait_valid("prio_first", 1'b0, lat);
      irq_ack = 1'b1;
      @(negedge PCLK);
      irq_ack = 1'b0;
      wait_valid("prio_second", 1'b0, lat);
      IRQ = 1'b0;
      repeat (3) @(negedge PCLK);
      chk("prio_hold", 64'({irq_valid, irq_id}), 64'({1'b1, 3'd5}));
      irq_ack = 1'b1;
      @(negedge PCLK);
      irq_ack = 1'b0;
      drain("prio");

      service(8'h08, 3'd3, 32'h08, -1, "irq_pulse");
      service(8'h00, 3'd0, 32'h00, -1, "spurious");
      chk("spurious_one", 64'(spurious_cnt), 64'(1));
      for (int i = 0; i < 299; i++) service(8'h00, 3'd0, 32'h00, -1, "spurious_rep");
      chk("spurious_sat", 64'(spurious_cnt), 64'(255));

      // Lock onto the kick timer phase using an undeferred kick.
      wait_kicks(2);
      drain("kick_sync");
      c_o = last_kick_cyc;
      kicks_scored = 1'b1;

      // Kick expires mid-DELIVER and must follow the clear write.
      wait_until(c_o + int'(K) - 10);
      status_q.push_back(8'h02);
      exp_q.push_back(mk(KRD, ST_A, 32'h02));
      exp_q.push_back(mk(KDLV, 8'h00, 32'd1));
      exp_q.push_back(mk(KWR, CLR_A, 32'h02));
      exp_q.push_back(mk(KWR, WD_A, KEY));
      IRQ = 1'b1;
      wait_valid("kick_deliver", 1'b1, lat);
      wait_until(c_o + int'(K) + 4);
      chk("kick_deferred", 64'({irq_valid, PSEL}), 64'({1'b1, 1'b0}));
      irq_ack = 1'b1;
      @(negedge PCLK);
      irq_ack = 1'b0;
      drain("kick_deliver");

      // IRQ and a fresh kick_pending meet in IDLE: kick first.
      wait_until(c_o + 2 * int'(K) - 2);
      status_q.push_back(8'h40);
      exp_q.push_back(mk(KWR, WD_A, KEY));
      exp_q.push_back(mk(KRD, ST_A, 32'h40));
      exp_q.push_back(mk(KDLV, 8'h00, 32'd6));
      exp_q.push_back(mk(KWR, CLR_A, 32'h40));
      IRQ = 1'b1;
      wait_valid("kick_first", 1'b1, lat);
      irq_ack = 1'b1;
      @(negedge PCLK);
      irq_ack = 1'b0;
      drain("kick_first");
      kicks_scored = 1'b0;

      // Watchdog flag is sticky.
      WDOG = 1'b1;
      @(negedge PCLK);
      WDOG = 1'b0;
      @(negedge PCLK);
      chk("wdog_set", 64'(wdog_fired), 64'(1));
      repeat (5) @(negedge PCLK);
      chk("wdog_sticky", 64'(wdog_fired), 64'(1));

      // Reset in the middle of a read access.
      wait_cfg = 5;
      IRQ = 1'b1;
      lat = 0;
      do begin
         @(negedge PCLK);
         lat++;
      end while (!(PSEL && PENABLE && !PWRITE) && lat < 200);
      if (!(PSEL && PENABLE)) timeout("rst_mid_access");
      #1 PRESETN = 1'b0;
      #1 chk("rst_async_drop", 64'({PSEL, PENABLE}), 64'(0));
      IRQ = 1'b0;
      wait_cfg = 0;
      @(negedge PCLK);
      PRESETN = 1'b1;
      @(negedge PCLK);
      chk("post_rst_apb", 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 64'(0));
      chk("post_rst_irq", 64'({irq_valid, irq_id}), 64'(0));
      chk("post_rst_cnt", 64'({spurious_cnt, wdog_fired}), 64'(0));
      service(8'h80, 3'd7, 32'h80, 3, "post_rst");

      chk("sb_empty", 64'(exp_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
